// File: rtl/pmp_region_scanner.sv
// Sequential PMP checker: scans NUM_ENTRIES OFF/TOR/NA4/NAPOT entries one per cycle,
// lowest index first, and reports full/partial match plus the R/W/X/L permission outcome.
`timescale 1ns/1ps
module pmp_region_scanner #(
  parameter int NUM_ENTRIES = 16,
  parameter int XLEN        = 32,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [XLEN-1:0]             req_addr,
  input  logic [1:0]                  req_size,
  input  logic [1:0]                  req_type,
  input  logic                        req_priv_m,
  input  logic [8*NUM_ENTRIES-1:0]    pmpcfg_i,
  input  logic [XLEN*NUM_ENTRIES-1:0] pmpaddr_i,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_allow,
  output logic                        resp_match,
  output logic [IDX_W-1:0]            resp_idx
);

  localparam int W = XLEN + 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

  logic [1:0]       state;
  logic [XLEN-1:0]  addr_q;
  logic [1:0]       size_q;
  logic [1:0]       type_q;
  logic             priv_q;
  logic [IDX_W-1:0] k;

  logic [7:0]      cfg_arr [NUM_ENTRIES];
  logic [XLEN-1:0] pa_arr  [NUM_ENTRIES];

  logic [7:0]      cur_cfg;
  logic [XLEN-1:0] cur_pa;
  logic [XLEN-1:0] prev_pa;
  logic [XLEN-1:0] napot_mask;
  logic [W-1:0]    acc_lo, acc_hi, lo, hi;
  logic            region_on, full, partial, perm_bit, grant, nomatch_allow;
  logic            unused_cfg_bits;

  assign req_ready  = (state == IDLE) && !reset;
  assign resp_valid = (state == RESP);

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_arr[i] = pmpcfg_i[8*i +: 8];
      pa_arr[i]  = pmpaddr_i[XLEN*i +: XLEN];
    end
  end

  // Bounds are widened to XLEN+3 bits so neither the access end nor a NAPOT top can wrap.
  always_comb begin
    cur_cfg    = cfg_arr[k];
    cur_pa     = pa_arr[k];
    prev_pa    = (k == '0) ? '0 : pa_arr[k - IDX_W'(1)];
    napot_mask = cur_pa ^ (cur_pa + XLEN'(1));
    acc_lo     = W'(addr_q);
    acc_hi     = acc_lo + (W'(1) << size_q);
    lo         = '0;
    hi         = '0;
    region_on  = 1'b0;
    case (cur_cfg[4:3])
      2'd1: begin
        lo        = {1'b0, prev_pa, 2'b00};
        hi        = {1'b0, cur_pa, 2'b00};
        region_on = (lo < hi);
      end
      2'd2: begin
        lo        = {1'b0, cur_pa, 2'b00};
        hi        = lo + W'(4);
        region_on = 1'b1;
      end
      2'd3: begin
        lo        = {1'b0, cur_pa & ~napot_mask, 2'b00};
        hi        = lo + ((W'(napot_mask) + W'(1)) << 2);
        region_on = 1'b1;
      end
      default: region_on = 1'b0;
    endcase
    full    = region_on && (lo <= acc_lo) && (acc_hi <= hi);
    partial = region_on && (acc_lo < hi) && (acc_hi > lo) && !full;
    case (type_q)
      2'b00:   perm_bit = cur_cfg[0];
      2'b01:   perm_bit = cur_cfg[1];
      2'b10:   perm_bit = cur_cfg[2];
      default: perm_bit = 1'b0;
    endcase
    grant         = full && (type_q != 2'b11) && ((priv_q && !cur_cfg[7]) || perm_bit);
    nomatch_allow = priv_q && (type_q != 2'b11);
  end

  assign unused_cfg_bits = ^cur_cfg[6:5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      type_q     <= '0;
      priv_q     <= 1'b0;
      k          <= '0;
      resp_allow <= 1'b0;
      resp_match <= 1'b0;
      resp_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            size_q <= req_size;
            type_q <= req_type;
            priv_q <= req_priv_m;
            k      <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (full || partial) begin
            resp_match <= 1'b1;
            resp_idx   <= k;
            resp_allow <= grant;
            state      <= RESP;
          end else if (k == LAST) begin
            resp_match <= 1'b0;
            resp_idx   <= '0;
            resp_allow <= nomatch_allow;
            state      <= RESP;
          end else begin
            k <= k + IDX_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_region_scanner.sv
// Table-driven bench for pmp_region_scanner (4 entries) with a response scoreboard,
// plus hand-written backpressure and mid-scan reset sequences.
`timescale 1ns/1ps
module tb_pmp_region_scanner;

  localparam int N = 4;
  localparam int XLEN = 32;
  localparam int IDX_W = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr = '0;
  logic [1:0]        req_size = '0;
  logic [1:0]        req_type = '0;
  logic              req_priv_m = 1'b0;
  logic [8*N-1:0]    pmpcfg = '0;
  logic [XLEN*N-1:0] pmpaddr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic              resp_allow;
  logic              resp_match;
  logic [IDX_W-1:0]  resp_idx;

  pmp_region_scanner #(.NUM_ENTRIES(N), .XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type), .req_priv_m(req_priv_m),
    .pmpcfg_i(pmpcfg), .pmpaddr_i(pmpaddr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_allow(resp_allow), .resp_match(resp_match), .resp_idx(resp_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  cfg;
    logic [127:0] pa;
    logic [31:0]  addr;
    logic [1:0]   size;
    logic [1:0]   rtype;
    logic         priv;
    logic         allow;
    logic         match;
    logic [1:0]   idx;
    int           lat;
  } vec_t;

  typedef struct {
    logic       allow;
    logic       match;
    logic [1:0] idx;
    int         lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] cfg, input logic [127:0] pa, input logic [31:0] addr,
                         input logic [1:0] size, input logic [1:0] rtype, input logic priv,
                         input logic allow, input logic match, input logic [1:0] idx, input int lat);
    vec_t v;
    v.cfg = cfg; v.pa = pa; v.addr = addr; v.size = size; v.rtype = rtype; v.priv = priv;
    v.allow = allow; v.match = match; v.idx = idx; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (one after acceptance).
  task automatic apply_stimulus(input vec_t v, input string tag);
    exp_t e;
    int w;
    pmpcfg = v.cfg; pmpaddr = v.pa;
    req_addr = v.addr; req_size = v.size; req_type = v.rtype; req_priv_m = v.priv;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_output({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    e.allow = v.allow; e.match = v.match; e.idx = v.idx; e.lat = v.lat;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic await_resp(input string tag);
    exp_t e;
    int cyc;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check_output({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check_output({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check_output({tag, "_allow"}, 32'(resp_allow), 32'(e.allow));
    check_output({tag, "_match"}, 32'(resp_match), 32'(e.match));
    check_output({tag, "_idx"}, 32'(resp_idx), 32'(e.idx));
  endtask

  task automatic finish_handshake(input string tag);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check_output({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
  endtask

  localparam logic [31:0]  CFG_A = 32'h0000_0089;
  localparam logic [127:0] PA_A  = {32'h0, 32'h0, 32'h0, 32'h400};
  localparam logic [31:0]  CFG_B = 32'h001C_0000;
  localparam logic [127:0] PA_B  = {32'h0, 32'h7FF, 32'h0, 32'h0};
  localparam logic [31:0]  CFG_C = 32'h0000_1000;
  localparam logic [31:0]  CFG_D = 32'h0000_9000;
  localparam logic [127:0] PA_C  = {32'h0, 32'h0, 32'h800, 32'h0};
  localparam logic [31:0]  CFG_E = 32'h0009_0900;
  localparam logic [127:0] PA_E  = {32'h0, 32'h1000, 32'h800, 32'h800};
  localparam logic [31:0]  CFG_F = 32'h1A00_0000;
  localparam logic [127:0] PA_F  = {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  initial begin
    vec_t v;
    int hi_seen;

    add_vec(CFG_A, PA_A, 32'h0000_0FFC, 2'd2, 2'b00, 1'b0, 1'b1, 1'b1, 2'd0, 2);
    add_vec(CFG_A, PA_A, 32'h0000_0FFE, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1, 2'd0, 2);
    add_vec(CFG_A, PA_A, 32'h0000_1000, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 5);
    add_vec(CFG_A, PA_A, 32'h0000_1000, 2'd0, 2'b00, 1'b1, 1'b1, 1'b0, 2'd0, 5);
    add_vec(CFG_B, PA_B, 32'h0000_3FF8, 2'd3, 2'b10, 1'b0, 1'b1, 1'b1, 2'd2, 4);
    add_vec(CFG_B, PA_B, 32'h0000_3FFC, 2'd3, 2'b10, 1'b0, 1'b0, 1'b1, 2'd2, 4);
    add_vec(CFG_B, PA_B, 32'h0000_3FF8, 2'd3, 2'b00, 1'b0, 1'b0, 1'b1, 2'd2, 4);
    add_vec(CFG_B, PA_B, 32'h0000_0100, 2'd2, 2'b00, 1'b1, 1'b1, 1'b1, 2'd2, 4);
    add_vec(CFG_C, PA_C, 32'h0000_2000, 2'd2, 2'b01, 1'b1, 1'b1, 1'b1, 2'd1, 3);
    add_vec(CFG_D, PA_C, 32'h0000_2000, 2'd2, 2'b01, 1'b1, 1'b0, 1'b1, 2'd1, 3);
    add_vec(CFG_C, PA_C, 32'h0000_2000, 2'd2, 2'b01, 1'b0, 1'b0, 1'b1, 2'd1, 3);
    add_vec(CFG_C, PA_C, 32'h0000_2000, 2'd2, 2'b11, 1'b1, 1'b0, 1'b1, 2'd1, 3);
    add_vec(CFG_E, PA_E, 32'h0000_1FFE, 2'd2, 2'b00, 1'b0, 1'b0, 1'b1, 2'd2, 4);
    add_vec(CFG_E, PA_E, 32'h0000_3000, 2'd2, 2'b00, 1'b0, 1'b1, 1'b1, 2'd2, 4);
    add_vec(CFG_F, PA_F, 32'hFFFF_FFF8, 2'd3, 2'b01, 1'b0, 1'b1, 1'b1, 2'd3, 5);
    add_vec(CFG_F, PA_F, 32'hFFFF_FFF8, 2'd3, 2'b00, 1'b0, 1'b0, 1'b1, 2'd3, 5);

    repeat (2) @(negedge clk);
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_allow", 32'(resp_allow), 32'd0);
    check_output("rst_match", 32'(resp_match), 32'd0);
    check_output("rst_idx", 32'(resp_idx), 32'd0);
    reset = 1'b0;
    #1;
    check_output("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], $sformatf("v%0d", i));
      await_resp($sformatf("v%0d", i));
      finish_handshake($sformatf("v%0d", i));
    end

    // Backpressure: response held, competing request ignored.
    resp_ready = 1'b0;
    apply_stimulus(vecs[0], "bp");
    await_resp("bp");
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_addr = 32'h0000_3FF8; req_type = 2'b10;
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("bp_hold%0d_valid", c), 32'(resp_valid), 32'd1);
      check_output($sformatf("bp_hold%0d_ready", c), 32'(req_ready), 32'd0);
      check_output($sformatf("bp_hold%0d_allow", c), 32'(resp_allow), 32'd1);
      check_output($sformatf("bp_hold%0d_match", c), 32'(resp_match), 32'd1);
      check_output($sformatf("bp_hold%0d_idx", c), 32'(resp_idx), 32'd0);
    end
    req_valid = 1'b0;
    finish_handshake("bp");
    @(negedge clk);
    check_output("bp_no_ghost", 32'(resp_valid), 32'd0);

    // Reset during SCAN cycle 2 drops the pending response.
    v = vecs[4];
    apply_stimulus(v, "mr");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("mr_req_ready", 32'(req_ready), 32'd0);
    check_output("mr_resp_valid", 32'(resp_valid), 32'd0);
    check_output("mr_allow", 32'(resp_allow), 32'd0);
    check_output("mr_match", 32'(resp_match), 32'd0);
    check_output("mr_idx", 32'(resp_idx), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("mr_release_ready", 32'(req_ready), 32'd1);
    hi_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) hi_seen++;
    end
    check_output("mr_dropped", 32'(hi_seen), 32'd0);
    apply_stimulus(vecs[5], "mr_after");
    await_resp("mr_after");
    finish_handshake("mr_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_region_scanner.md
# pmp_region_scanner

Sequential, parametrised PMP checker that generalises the single-entry combinational TOR matcher to NUM_ENTRIES entries in OFF/TOR/NA4/NAPOT mode. It accepts one access request per handshake, scans entries one per cycle in priority order (lowest index wins), detects full and partial matches, and applies R/W/X/L permissions. It sits between the core's load/store/fetch address stage and the bus, with the CSR file supplying pmpcfg/pmpaddr.

## Interface
- NUM_ENTRIES, 16, number of PMP entries (1..16)
- XLEN, 32, address and pmpaddr width
- IDX_W, $clog2(NUM_ENTRIES) (min 1), entry-index width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle, can accept
- req_addr  in  XLEN  byte address
- req_size  in  2  access is 2^req_size bytes (1/2/4/8)
- req_type  in  2  00 read, 01 write, 10 execute, 11 reserved
- req_priv_m  in  1  request from M-mode
- pmpcfg_i  in  8*NUM_ENTRIES  entry k at [8k+7:8k]: R=0, W=1, X=2, A=4:3 (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), L=7
- pmpaddr_i  in  XLEN*NUM_ENTRIES  entry k at [XLEN*k+XLEN-1:XLEN*k], holds byte address >> 2
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_allow  out  1  access permitted
- resp_match  out  1  some entry matched (full or partial)
- resp_idx  out  IDX_W  matching entry index (0 if none)

## Operation
- FSM: IDLE, SCAN, RESP. Reset -> IDLE.
- IDLE: req_ready=1. req_valid&&req_ready captures addr/size/type/priv, entry counter k=0, -> SCAN.
- SCAN: evaluate entry k per cycle. All bound arithmetic in XLEN+3 bits (no wrap). Access range [A, E), A=req_addr, E=A+2^size.
- Region [lo, hi) per mode: OFF never matches. TOR: lo = (k==0) ? 0 : pmpaddr[k-1]<<2, hi = pmpaddr[k]<<2; lo>=hi never matches. NA4: lo=pmpaddr[k]<<2, hi=lo+4. NAPOT: t = trailing ones of pmpaddr[k]; lo = (pmpaddr[k] with low t+1 bits cleared)<<2, hi = lo + 2^(t+3); all-ones pmpaddr covers the whole space.
- Full match: lo<=A && E<=hi. Partial: A<hi && E>lo && !full.
- First entry with full or partial match ends the scan -> RESP, resp_match=1, resp_idx=k.
  - Partial: resp_allow=0.
  - Full: resp_allow = (priv_m && !L) ? 1 : permission bit for req_type (R/W/X).
- k==NUM_ENTRIES-1 with no match -> RESP, resp_match=0, resp_idx=0, resp_allow=priv_m.
- req_type 11: resp_allow=0 regardless of match.
- RESP: resp_valid=1, outputs held stable until resp_valid&&resp_ready, then -> IDLE. No request accepted in SCAN/RESP.
- pmpcfg_i/pmpaddr_i read live during SCAN; integrator keeps them stable from accept to response.

## Timing
- Reset values: req_ready=0 while reset asserted, 1 in IDLE after release; resp_valid=0, resp_allow=0, resp_match=0, resp_idx=0.
- Accept in cycle 0; entry k evaluated in cycle k+1; resp_valid rises in cycle m+2 for match at entry m, in cycle NUM_ENTRIES+1 on no match.
- With resp_ready held high: next req_ready one cycle after response handshake (throughput one request per m+3 cycles).
- Reset mid-SCAN or mid-RESP: immediate return to IDLE, response dropped, outputs to reset values.
- resp_valid never deasserts without resp_ready.

## Test plan
- NUM_ENTRIES=4; entry0 TOR pmpaddr0=0x400, cfg R=1,L=1; read addr 0xFFC size 2, U-mode -> allow=1, match=1, idx=0, resp_valid at cycle 2.
- Same setup; write addr 0xFFE size 2 (crosses 0x1000) -> partial, match=1, idx=0, allow=0; read addr 0x1000 size 0 -> no match, U-mode allow=0, M-mode allow=1, resp_valid at cycle 5.
- entry2 NAPOT pmpaddr=0x7FF (lo 0x0, hi 0x4000), cfg X=1, entries 0/1 OFF; exec addr 0x3FF8 size 3 -> allow=1, idx=2, resp at cycle 4; exec 0x3FFC size 3 -> partial, allow=0.
- entry1 NA4 pmpaddr=0x800 (0x2000..0x2004) cfg L=0 no perms; M-mode write 0x2000 size 2 -> allow=1; set L=1 -> allow=0; U-mode -> allow=0.
- Backpressure: resp_ready=0 for 5 cycles -> outputs stable, req_ready=0, new req_valid ignored; release -> handshake, req_ready=1 next cycle.
- Assert reset in SCAN cycle 2 -> all outputs reset values, no response; after release new request completes normally; TOR entry with lo>=hi never matches.
